// File: rtl/dm_be_mc.sv
// dm_be_mc: byte-enabled data memory for the multicycle/pipelined MIPS core.
//   Word-organised storage (DEPTH = 2**ADDR_WIDTH words) with LB/LBU/LH/LHU/LW
//   loads, SB/SH/SW read-modify-write stores, LATENCY-cycle req/ready/resp
//   handshake, misalignment/range error reporting and a post-reset clear sweep.
// Ports:
//   clk, rst       clock (posedge), asynchronous active-high reset
//   pc             PC of issuing instruction (trace only)
//   req/op/addr/wdata  request; held stable while req=1
//   req_ready      request accepted on the next edge when high
//   resp_valid     one-cycle completion pulse, qualifies rdata/resp_err
//   rdata          extended load data (0 for stores and errors)
//   resp_err       misaligned or out-of-range access
//   init_done      clear sweep finished
// Optional: define DM_BE_MC_TRACE_EN to print each successful store commit.
module dm_be_mc #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic        init_done
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] sweep_ptr;
  logic [3:0]            cnt;
  logic [2:0]            op_l;
  logic [31:0]           addr_l, wdata_l, pc_l;
  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]           word, merged, ld;
  logic [7:0]            bsel_b;
  logic [15:0]           bsel_h;
  logic                  is_store, mis, rng, err, commit, accept;

  // ---------------- access decode on latched request ----------------
  always_comb begin
    widx     = addr_l[ADDR_WIDTH+1:2];
    word     = mem[widx];
    bsel_b   = word[8*addr_l[1:0] +: 8];
    bsel_h   = word[16*addr_l[1] +: 16];
    is_store = (op_l >= OP_SW);
    mis      = 1'b0;
    case (op_l)
      OP_LW, OP_SW:         mis = |addr_l[1:0];
      OP_LH, OP_LHU, OP_SH: mis = addr_l[0];
      default:              mis = 1'b0;
    endcase
    // Anything above the word-index bits must be zero.
    rng = |(addr_l >> (ADDR_WIDTH+2));
    err = mis | rng;

    merged = word;
    case (op_l)
      OP_SW:   merged = wdata_l;
      OP_SH:   merged[16*addr_l[1] +: 16] = wdata_l[15:0];
      OP_SB:   merged[8*addr_l[1:0] +: 8] = wdata_l[7:0];
      default: merged = word;
    endcase

    ld = 32'h0;
    case (op_l)
      OP_LW:   ld = word;
      OP_LH:   ld = {{16{bsel_h[15]}}, bsel_h};
      OP_LHU:  ld = {16'h0, bsel_h};
      OP_LB:   ld = {{24{bsel_b[7]}}, bsel_b};
      OP_LBU:  ld = {24'h0, bsel_b};
      default: ld = 32'h0;
    endcase
  end

  assign commit    = (state == S_WAIT) && (cnt == 4'd0);
  assign req_ready = (state == S_IDLE);
  assign accept    = req_ready && req;

  // ---------------- FSM ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (&sweep_ptr) state_nx = S_IDLE;
      S_IDLE:  if (req) state_nx = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  // ---------------- control / response registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_ptr  <= '0;
      cnt        <= 4'd0;
      op_l       <= 3'd0;
      addr_l     <= 32'h0;
      wdata_l    <= 32'h0;
      pc_l       <= 32'h0;
      resp_valid <= 1'b0;
      rdata      <= 32'h0;
      resp_err   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      resp_valid <= commit;
      if (state == S_INIT) begin
        sweep_ptr <= sweep_ptr + 1'b1;
        if (&sweep_ptr) init_done <= 1'b1;
      end
      if (accept) begin
        op_l    <= op;
        addr_l  <= addr;
        wdata_l <= wdata;
        pc_l    <= pc;
        cnt     <= 4'(LATENCY-1);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rdata    <= (err || is_store) ? 32'h0 : ld;
        resp_err <= err;
      end
    end
  end

  // ---------------- storage array (not reset; cleared by the sweep) ----------------
  always_ff @(posedge clk) begin
    if (state == S_INIT)
      mem[sweep_ptr] <= 32'h0;
    else if (commit && is_store && !err) begin
      mem[widx] <= merged;
`ifdef DM_BE_MC_TRACE_EN
      $display("@%h: *%h <= %h", pc_l, {addr_l[31:2], 2'b00}, merged);
`endif
    end
  end

`ifndef DM_BE_MC_TRACE_EN
  // pc only feeds the trace print.
  logic unused_pc;
  assign unused_pc = ^pc_l;
`endif

endmodule

// File: tb/tb_dm_be_mc.sv
// Directed bench for dm_be_mc. Instance A: ADDR_WIDTH=4, LATENCY=1 (sweep
// length, byte lanes, errors). Instance B: ADDR_WIDTH=12, LATENCY=3 (handshake
// timing, range error, reset mid-access).
module tb_dm_be_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_req, a_ready, a_rv, a_err, a_idn;
  logic [2:0]  a_op;
  logic [31:0] a_pc, a_addr, a_wdata, a_rdata;
  logic        b_rst, b_req, b_ready, b_rv, b_err, b_idn;
  logic [2:0]  b_op;
  logic [31:0] b_pc, b_addr, b_wdata, b_rdata;

  int nchk = 0;
  int nerr = 0;

  dm_be_mc #(.ADDR_WIDTH(4), .LATENCY(1)) u_a (
    .clk(clk), .rst(a_rst), .pc(a_pc), .req(a_req), .op(a_op), .addr(a_addr),
    .wdata(a_wdata), .req_ready(a_ready), .resp_valid(a_rv), .rdata(a_rdata),
    .resp_err(a_err), .init_done(a_idn));

  dm_be_mc #(.ADDR_WIDTH(12), .LATENCY(3)) u_b (
    .clk(clk), .rst(b_rst), .pc(b_pc), .req(b_req), .op(b_op), .addr(b_addr),
    .wdata(b_wdata), .req_ready(b_ready), .resp_valid(b_rv), .rdata(b_rdata),
    .resp_err(b_err), .init_done(b_idn));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc_a(input logic [2:0] o, input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    a_req = 1'b1; a_op = o; a_addr = ad; a_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    a_req = 1'b0;
    n = 0;
    while (!a_rv && n < 50) begin @(negedge clk); n++; end
    chk("a_resp_seen", {31'b0, a_rv}, 32'd1);
    rd = a_rdata; e = a_err;
  endtask

  task automatic acc_b(input logic [2:0] o, input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    b_req = 1'b1; b_op = o; b_addr = ad; b_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    b_req = 1'b0;
    n = 0;
    while (!b_rv && n < 50) begin @(negedge clk); n++; end
    chk("b_resp_seen", {31'b0, b_rv}, 32'd1);
    rd = b_rdata; e = b_err;
  endtask

  task automatic wait_b_init();
    int n;
    n = 0;
    while (!b_idn && n < 5000) begin @(negedge clk); n++; end
    chk("b_init_done", {31'b0, b_idn}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        e;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_req = 1'b0; a_op = 3'd0; a_addr = 32'h0; a_wdata = 32'h0; a_pc = 32'h3008;
    b_req = 1'b0; b_op = 3'd0; b_addr = 32'h0; b_wdata = 32'h0; b_pc = 32'h0;
    #1;
    chk("rst_ready",  {31'b0, a_ready}, 32'd0);
    chk("rst_rv",     {31'b0, a_rv},    32'd0);
    chk("rst_rdata",  a_rdata,          32'd0);
    chk("rst_err",    {31'b0, a_err},   32'd0);
    chk("rst_idn",    {31'b0, a_idn},   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    // INIT sweep, 16 words: ready/init_done low until the 16th edge.
    chk("init_c0", {30'b0, a_ready, a_idn}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("init_c%0d", i), {30'b0, a_ready, a_idn}, 32'd0);
    end
    @(negedge clk);
    chk("init_end", {30'b0, a_ready, a_idn}, 32'd3);

    acc_a(3'd0, 32'h3C, 32'h0, rd, e);   chk("lw3c_cleared", rd, 32'h0);

    // Byte lanes, LATENCY=1
    acc_a(3'd5, 32'h10, 32'h8899AABB, rd, e);
    chk("sw_rdata", rd, 32'h0); chk("sw_err", {31'b0, e}, 32'd0);
    acc_a(3'd7, 32'h11, 32'hFFFFFF5C, rd, e);
    acc_a(3'd0, 32'h10, 32'h0, rd, e);   chk("lw10", rd, 32'h88995CBB);
    acc_a(3'd3, 32'h11, 32'h0, rd, e);   chk("lb11", rd, 32'h0000005C);
    acc_a(3'd1, 32'h12, 32'h0, rd, e);   chk("lh12", rd, 32'hFFFF8899);
    acc_a(3'd2, 32'h12, 32'h0, rd, e);   chk("lhu12", rd, 32'h00008899);
    acc_a(3'd3, 32'h10, 32'h0, rd, e);   chk("lb10", rd, 32'hFFFFFFBB);
    acc_a(3'd4, 32'h10, 32'h0, rd, e);   chk("lbu10", rd, 32'h000000BB);

    // Errors
    acc_a(3'd6, 32'h13, 32'h0000DEAD, rd, e); chk("sh13_err", {31'b0, e}, 32'd1);
    acc_a(3'd0, 32'h10, 32'h0, rd, e);   chk("lw10_unchanged", rd, 32'h88995CBB);
    acc_a(3'd0, 32'h02, 32'h0, rd, e);
    chk("lw02_err", {31'b0, e}, 32'd1); chk("lw02_rdata", rd, 32'h0);
    acc_a(3'd0, 32'h40, 32'h0, rd, e);   chk("lw40_range", {31'b0, e}, 32'd1);
    acc_a(3'd6, 32'h12, 32'hFFFF1234, rd, e); chk("sh12_ok", {31'b0, e}, 32'd0);
    acc_a(3'd0, 32'h10, 32'h0, rd, e);   chk("lw10_sh", rd, 32'h12345CBB);

    // Instance B: LATENCY=3 handshake timing
    wait_b_init();
    @(negedge clk);
    chk("b_ready_idle", {31'b0, b_ready}, 32'd1);
    b_req = 1'b1; b_op = 3'd0; b_addr = 32'h0;
    @(posedge clk);                                   // E0
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("lat_wait%0d", i), {30'b0, b_ready, b_rv}, 32'd0);
    end
    @(negedge clk);                                   // after E3
    chk("lat_resp", {30'b0, b_ready, b_rv}, 32'd3);
    chk("lat_rdata", b_rdata, 32'h0);
    @(negedge clk);                                   // held req taken at E4
    chk("lat_reaccept", {30'b0, b_ready, b_rv}, 32'd0);
    b_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("lat2_wait%0d", i), {31'b0, b_rv}, 32'd0);
    end
    @(negedge clk);
    chk("lat2_resp", {31'b0, b_rv}, 32'd1);

    acc_b(3'd0, 32'h4000, 32'h0, rd, e); chk("b_lw4000_range", {31'b0, e}, 32'd1);
    acc_b(3'd5, 32'h24, 32'hCAFEF00D, rd, e);
    acc_b(3'd0, 32'h24, 32'h0, rd, e);   chk("b_lw24", rd, 32'hCAFEF00D);

    // Reset in the middle of a store
    @(negedge clk);
    b_req = 1'b1; b_op = 3'd5; b_addr = 32'h20; b_wdata = 32'h12345678;
    @(posedge clk);                                   // E0
    #1 b_req = 1'b0;
    @(posedge clk);
    @(posedge clk);                                   // E2
    #2 b_rst = 1'b1;
    #1;
    chk("mid_rst_outs", {29'b0, b_ready, b_rv, b_idn}, 32'd0);
    @(negedge clk);
    b_rst = 1'b0;
    wait_b_init();
    acc_b(3'd0, 32'h20, 32'h0, rd, e);   chk("b_lw20_after_rst", rd, 32'h0);
    acc_b(3'd0, 32'h24, 32'h0, rd, e);   chk("b_lw24_swept", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
